cvp_sys_mem: RTL and testbench

//  System memory for the CVP14 core. Sits directly downstream of the core's Addr/RD/WR/DataOut bus and feeds its DataIn.
//  The core never stalls, so every read returns with a fixed 1-cycle latency.

---
 rtl/cvp_pkg.sv | 15 +
 rtl/cvp_wbuf.sv | 64 ++++++
 rtl/cvp_sys_mem.sv | 118 +++++++++++
 tb/tb_cvp_sys_mem.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cvp_pkg.sv
// Shared types and constants for the CVP14 system memory and its write buffer.
package cvp_pkg;
    localparam int WORD_W = 16;
    localparam int AW     = 16;

    // Data returned on the bus for an out-of-range read
    localparam logic [WORD_W-1:0] OOR_RDATA = '0;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [WORD_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {ST_INIT, ST_RUN} mem_state_e;
endpackage

// File: rtl/cvp_wbuf.sv
// Posted-write buffer: WB_DEPTH-entry FIFO plus a youngest-match address lookup
// used to forward buffered data to reads.
module cvp_wbuf
    import cvp_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  wb_entry_t         push_entry_i,
    input  logic              pop_i,
    output wb_entry_t         head_o,
    output logic              empty_o,
    output logic              full_o,
    input  logic [AW-1:0]     lkup_addr_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] hit_data_o
);
    localparam int PW = $clog2(WB_DEPTH);

    wb_entry_t     ent_q [WB_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) ent_q[tail_q] <= push_entry_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign head_o  = ent_q[head_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PW+1)'(WB_DEPTH));

    // Walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (ent_q[idx].addr == lkup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = ent_q[idx].data;
            end
        end
    end
endmodule

// File: rtl/cvp_sys_mem.sv
// CVP14 system memory: fixed 1-cycle reads, posted writes via cvp_wbuf, single-port word SRAM.
// Build option MEM_INIT_EN: zero-fill the SRAM after reset before raising Ready.
module cvp_sys_mem
    import cvp_pkg::*;
#(
    parameter int AW         = cvp_pkg::AW,
    parameter int DEPTH_LOG2 = 12,
    parameter int WB_DEPTH   = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [AW-1:0]     Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [WORD_W-1:0] WData,
    output logic [WORD_W-1:0] RData,
    output logic              Ready,
    output logic              AddrErr,
    output logic              WbOvf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0]     sram_q [DEPTH];
    logic [WORD_W-1:0]     rdata_q;
    logic                  ready_q, addr_err_q, wb_ovf_q;
    logic                  init_we;
    logic [DEPTH_LOG2-1:0] init_addr;

    logic              in_rng, rd_acc, wr_acc, push, pop, empty, full, hit;
    logic [WORD_W-1:0] hit_data;
    wb_entry_t         head, push_ent;
    logic              unused_head_hi;

    assign in_rng = ((Addr >> DEPTH_LOG2) == '0);
    assign rd_acc = ready_q & RD;
    assign wr_acc = ready_q & WR;
    // The SRAM port belongs to the read whenever RD is up, so drain only on RD=0
    assign pop    = ready_q & ~RD & ~empty;
    assign push   = wr_acc & in_rng & (~full | pop);

    assign push_ent.addr  = Addr;
    assign push_ent.data  = WData;
    assign unused_head_hi = |(head.addr >> DEPTH_LOG2);

    cvp_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .push_i       (push),
        .push_entry_i (push_ent),
        .pop_i        (pop),
        .head_o       (head),
        .empty_o      (empty),
        .full_o       (full),
        .lkup_addr_i  (Addr),
        .hit_o        (hit),
        .hit_data_o   (hit_data)
    );

`ifdef MEM_INIT_EN
    mem_state_e            state_q;
    logic [DEPTH_LOG2-1:0] init_cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (&init_cnt_q) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    assign init_we   = (state_q == ST_INIT);
    assign init_addr = init_cnt_q;
`else
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) ready_q <= 1'b0;
        else          ready_q <= 1'b1;
    end

    assign init_we   = 1'b0;
    assign init_addr = '0;
`endif

    always_ff @(posedge Clk) begin
        if (init_we)  sram_q[init_addr] <= '0;
        else if (pop) sram_q[head.addr[DEPTH_LOG2-1:0]] <= head.data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rdata_q    <= '0;
            addr_err_q <= 1'b0;
            wb_ovf_q   <= 1'b0;
        end else begin
            // Lookup sees the buffer before this cycle's push: RD+WR returns the old value
            if (rd_acc)
                rdata_q <= !in_rng ? OOR_RDATA :
                           hit     ? hit_data  : sram_q[Addr[DEPTH_LOG2-1:0]];
            if ((rd_acc | wr_acc) & ~in_rng) addr_err_q <= 1'b1;
            if (wr_acc & in_rng & full & RD) wb_ovf_q <= 1'b1;
        end
    end

    assign RData   = rdata_q;
    assign Ready   = ready_q;
    assign AddrErr = addr_err_q;
    assign WbOvf   = wb_ovf_q;
endmodule

// File: tb/tb_cvp_sys_mem.sv
// Randomized self-checking bench for cvp_sys_mem against a queue/array reference model.
module tb_cvp_sys_mem;
    localparam int AW  = 16;
    localparam int DL2 = 6;
    localparam int N   = 1 << DL2;
    localparam int WBD = 4;
`ifdef MEM_INIT_EN
    localparam int READY_LAT = N;
`else
    localparam int READY_LAT = 1;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    logic          Clk = 1'b0, Reset_n = 1'b0, RD = 1'b0, WR = 1'b0;
    logic [AW-1:0] Addr = '0;
    logic [15:0]   WData = '0;
    logic [15:0]   RData;
    logic          Ready, AddrErr, WbOvf;

    always #5 Clk = ~Clk;

    cvp_sys_mem #(.AW(AW), .DEPTH_LOG2(DL2), .WB_DEPTH(WBD)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR), .WData(WData),
        .RData(RData), .Ready(Ready), .AddrErr(AddrErr), .WbOvf(WbOvf)
    );

    int nchk = 0, nerr = 0;

    // Reference model: pending writes in order, committed memory, output state
    ent_t        q[$];
    logic [15:0] mem [N];
    bit          known [N];
    logic [15:0] m_rdata = '0;
    bit          m_rknown = 1'b1, m_aerr = 1'b0, m_ovf = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive, advance the model one edge, compare, return at next negedge
    task automatic cycle(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        bit   inr, full;
        int   hit;
        ent_t e;
        RD = rd; WR = wr; Addr = a; WData = d;
        inr  = (a < N);
        full = (q.size() == WBD);
        if (rd) begin
            if (!inr) begin
                m_rdata = '0; m_rknown = 1'b1; m_aerr = 1'b1;
            end else begin
                hit = -1;
                foreach (q[i]) if (q[i].a == a) hit = i;
                if (hit >= 0) begin
                    m_rdata = q[hit].d; m_rknown = 1'b1;
                end else begin
                    m_rdata = mem[a[DL2-1:0]]; m_rknown = known[a[DL2-1:0]];
                end
            end
        end
        if (wr && !inr) m_aerr = 1'b1;
        if (wr && inr && full && rd) m_ovf = 1'b1;
        if (!rd && q.size() > 0) begin
            e = q.pop_front();
            mem[e.a[DL2-1:0]]   = e.d;
            known[e.a[DL2-1:0]] = 1'b1;
        end
        if (wr && inr && !(full && rd)) begin
            e.a = a; e.d = d;
            q.push_back(e);
        end
        @(posedge Clk);
        #1;
        if (m_rknown) check("rdata", RData, m_rdata);
        check("ready", 16'(Ready), 16'(1));
        check("addrerr", 16'(AddrErr), 16'(m_aerr));
        check("wbovf", 16'(WbOvf), 16'(m_ovf));
        check("count", 16'(dut.u_wbuf.count_q), 16'(q.size()));
        @(negedge Clk);
        RD = 1'b0; WR = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        int cyc;
        Reset_n = 1'b0; RD = 1'b0; WR = 1'b0;
        #1;
        check("rst_ready", 16'(Ready), 16'(0));
        check("rst_rdata", RData, 16'h0000);
        check("rst_addrerr", 16'(AddrErr), 16'(0));
        check("rst_wbovf", 16'(WbOvf), 16'(0));
        check("rst_count", 16'(dut.u_wbuf.count_q), 16'(0));
        q.delete();
        m_rdata = '0; m_rknown = 1'b1; m_aerr = 1'b0; m_ovf = 1'b0;
`ifdef MEM_INIT_EN
        foreach (mem[i]) begin mem[i] = '0; known[i] = 1'b1; end
`endif
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        cyc = 0;
        while (cyc < N + 8) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (Ready) break;
        end
        check("ready_latency", 16'(cyc), 16'(READY_LAT));
        @(negedge Clk);
    endtask

    logic [15:0] vals [16];

    initial begin
        @(negedge Clk);
        do_reset();

        // Post-reset read of a low word
        cycle(1'b1, 1'b0, 16'h0005, 16'h0);

        // Forward from buffer, then read back from SRAM
        cycle(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        cycle(1'b1, 1'b0, 16'h0010, 16'h0);
        check("fwd_beef", RData, 16'hBEEF);
        idle(1);
        cycle(1'b1, 1'b0, 16'h0010, 16'h0);
        check("sram_beef", RData, 16'hBEEF);

        // Same address twice: youngest wins, both before and after drain
        cycle(1'b0, 1'b1, 16'h0020, 16'h1111);
        cycle(1'b0, 1'b1, 16'h0020, 16'h2222);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0);
        check("dup_fwd", RData, 16'h2222);
        idle(3);
        cycle(1'b1, 1'b0, 16'h0020, 16'h0);
        check("dup_sram", RData, 16'h2222);

        // Fill with RD held to block drain, then overflow
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(8 + i), 16'(16'hA0 + i));
        cycle(1'b1, 1'b1, 16'h000B, 16'hDEAD);
        check("ovf_flag", 16'(WbOvf), 16'(1));
        check("ovf_count", 16'(dut.u_wbuf.count_q), 16'(4));
        idle(5);
        cycle(1'b1, 1'b0, 16'h000B, 16'h0);
        check("ovf_dropped", RData, 16'h00A3);

        // Out-of-range read and write; OOR read blocks drain so count stays put
        cycle(1'b0, 1'b1, 16'h0005, 16'h5555);
        cycle(1'b1, 1'b1, 16'hF000, 16'h1234);
        check("oor_rdata", RData, 16'h0000);
        check("oor_addrerr", 16'(AddrErr), 16'(1));
        check("oor_count", 16'(dut.u_wbuf.count_q), 16'(1));
        idle(2);

        // Reset with three entries still waiting to drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 16'(16'h18 + i), 16'(16'hC0 + i));
        idle(1);
        check("pre_rst_count", 16'(dut.u_wbuf.count_q), 16'(3));
        do_reset();

        // 16-word store burst followed by a 16-word load burst
        for (int i = 0; i < 16; i++) begin
            vals[i] = 16'($urandom);
            cycle(1'b0, 1'b1, 16'(16'h30 + i), vals[i]);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 16'(16'h30 + i), 16'h0);
            check("burst", RData, vals[i]);
        end
        idle(4);

        for (int k = 0; k < 1500; k++) begin
            logic [15:0] a;
            int          r;
            r = int'($urandom_range(0, 15));
            if (r == 0)     a = 16'($urandom_range(N, 65535));
            else if (r < 8) a = 16'($urandom_range(0, 7));
            else            a = 16'($urandom_range(0, N - 1));
            cycle(1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
